// File: rtl/block_c_rr_merge.sv
// block_c_rr_merge: NUM_CH ready/valid inputs, each buffered in a DEPTH-entry FIFO, merged
// round-robin into one registered, channel-tagged output. Macro BLOCKC_MERGE_STATS_EN adds out_xfer_cnt.

module block_c_rr_merge_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_rdy,
    output logic              o_nempty,
    output logic [DATA_W-1:0] o_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     r_wr;
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     w_cnt;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Ready comes only from registered pointers, so a pop this cycle cannot reopen a full FIFO
    assign w_cnt    = r_wr - r_rd;
    assign o_rdy    = (w_cnt != PW'(DEPTH));
    assign o_nempty = (w_cnt != '0);
    assign w_push   = i_vld & o_rdy;
    assign w_pop    = i_pop & o_nempty;
    assign o_data   = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
        end
    end

    // Storage needs no reset: entries outside [rd, wr) are never read
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end
endmodule

module block_c_rr_merge #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          in_vld,
    output logic [NUM_CH-1:0]          in_rdy,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]  out_ch
`ifdef BLOCKC_MERGE_STATS_EN
    ,
    output logic [15:0]                out_xfer_cnt
`endif
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]             w_nempty;
    logic [NUM_CH-1:0]             w_pop;
    logic [NUM_CH-1:0][DATA_W-1:0] w_fdata;
    logic [CW-1:0]                 w_gnt;
    logic [CW-1:0]                 w_gnt_nxt;
    logic                          w_found;
    logic                          w_load;
    int                            w_idx;

    logic                          r_out_vld;
    logic [DATA_W-1:0]             r_out_data;
    logic [CW-1:0]                 r_out_ch;
    logic [CW-1:0]                 r_rr_ptr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        block_c_rr_merge_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_vld    (in_vld[g]),
            .i_data   (in_data[g*DATA_W +: DATA_W]),
            .i_pop    (w_pop[g]),
            .o_rdy    (in_rdy[g]),
            .o_nempty (w_nempty[g]),
            .o_data   (w_fdata[g])
        );
    end

    // First non-empty channel at or after rr_ptr, wrapping modulo NUM_CH
    always_comb begin
        w_gnt   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            if (!w_found && w_nempty[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = CW'(w_idx);
            end
        end
    end

    assign w_load    = !r_out_vld | out_rdy;
    assign w_gnt_nxt = (w_gnt == CW'(NUM_CH - 1)) ? '0 : w_gnt + CW'(1);

    always_comb begin
        w_pop = '0;
        if (w_load && w_found) w_pop[w_gnt] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_rr_ptr   <= '0;
        end else if (w_load) begin
            r_out_vld <= w_found;
            if (w_found) begin
                r_out_data <= w_fdata[w_gnt];
                r_out_ch   <= w_gnt;
                r_rr_ptr   <= w_gnt_nxt;
            end
        end
    end

    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign out_ch   = r_out_ch;

`ifdef BLOCKC_MERGE_STATS_EN
    logic [15:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_xfer_cnt <= '0;
        else if (r_out_vld && out_rdy && r_xfer_cnt != 16'hFFFF)
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end

    assign out_xfer_cnt = r_xfer_cnt;
`endif
endmodule

// File: tb/tb_block_c_rr_merge.sv
// Bench for block_c_rr_merge (4 channels, depth 4): directed table and corner sequences,
// then randomized traffic against a queue-based reference model.

module tb_block_c_rr_merge;
    localparam int DW = 32;
    localparam int NC = 4;
    localparam int DP = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC-1:0]     in_vld;
    logic [NC-1:0]     in_rdy;
    logic [NC*DW-1:0]  in_data;
    logic              out_vld;
    logic              out_rdy;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_ch;
`ifdef BLOCKC_MERGE_STATS_EN
    logic [15:0]       out_xfer_cnt;
`endif

    int checks = 0;
    int failures = 0;

    block_c_rr_merge #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_ch   (out_ch)
`ifdef BLOCKC_MERGE_STATS_EN
        ,
        .out_xfer_cnt (out_xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: per-channel queues plus the output register contents
    logic [DW-1:0] q [NC][$];
    logic          m_vld;
    logic [DW-1:0] m_data;
    int            m_ch;
    int            m_rr;
    int            m_cnt;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] d2;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  ech;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_vld  = '0;
        in_data = '0;
        out_rdy = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        m_vld = 1'b0; m_data = '0; m_ch = 0; m_rr = 0; m_cnt = 0;
        for (int k = 0; k < NC; k++) q[k].delete();
    endtask

    // One clock of the model: inputs already driven; check ready, clock, update, compare
    task automatic model_step();
        logic [NC-1:0]    vs;
        logic [NC-1:0]    er;
        logic             rs;
        logic [NC*DW-1:0] ds;
        int               g;
        vs = in_vld; rs = out_rdy; ds = in_data;
        for (int k = 0; k < NC; k++) er[k] = (q[k].size() != DP);
        chk("rnd_in_rdy", {60'd0, in_rdy}, {60'd0, er});
        tick();
        if (m_vld && rs && m_cnt != 65535) m_cnt++;
        if (!m_vld || rs) begin
            g = -1;
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (m_rr + i) % NC;
                if (g < 0 && q[c].size() != 0) g = c;
            end
            if (g >= 0) begin
                m_data = q[g].pop_front();
                m_ch   = g;
                m_vld  = 1'b1;
                m_rr   = (g + 1) % NC;
            end else begin
                m_vld = 1'b0;
            end
        end
        for (int k = 0; k < NC; k++)
            if (vs[k] && er[k]) q[k].push_back(ds[k*DW +: DW]);
        chk("rnd_out_vld", {63'd0, out_vld}, {63'd0, m_vld});
        if (m_vld) begin
            chk("rnd_out_data", {32'd0, out_data}, {32'd0, m_data});
            chk("rnd_out_ch", {62'd0, out_ch}, 64'(m_ch));
        end
`ifdef BLOCKC_MERGE_STATS_EN
        chk("xfer_cnt", {48'd0, out_xfer_cnt}, 64'(m_cnt));
`endif
    endtask

    initial begin
        int w, e, stale, mode;
        logic pre;

        do_reset();
        chk("rst_in_rdy", {60'd0, in_rdy}, 64'hF);
        chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_ch", {62'd0, out_ch}, 64'd0);

        // Single channel back-to-back: ch2 sends A0..A3, output follows one cycle later
        tbl[0] = '{4'b0100, 32'hA0, 1'b1, 1'b0, 32'h0,  2'd0};
        tbl[1] = '{4'b0100, 32'hA1, 1'b1, 1'b1, 32'hA0, 2'd2};
        tbl[2] = '{4'b0100, 32'hA2, 1'b1, 1'b1, 32'hA1, 2'd2};
        tbl[3] = '{4'b0100, 32'hA3, 1'b1, 1'b1, 32'hA2, 2'd2};
        tbl[4] = '{4'b0000, 32'h0,  1'b1, 1'b1, 32'hA3, 2'd2};
        tbl[5] = '{4'b0000, 32'h0,  1'b1, 1'b0, 32'h0,  2'd0};
        for (int i = 0; i < 6; i++) begin
            in_vld = tbl[i].vld;
            in_data[95:64] = tbl[i].d2;
            out_rdy = tbl[i].rdy;
            chk("tbl_in_rdy", {60'd0, in_rdy}, 64'hF);
            tick();
            chk("tbl_out_vld", {63'd0, out_vld}, {63'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk("tbl_out_data", {32'd0, out_data}, {32'd0, tbl[i].ed});
                chk("tbl_out_ch", {62'd0, out_ch}, {62'd0, tbl[i].ech});
            end
        end

        // Round robin: two words per channel preloaded, then drained
        do_reset();
        for (int j = 0; j < 2; j++) begin
            in_vld = 4'hF;
            for (int k = 0; k < NC; k++) in_data[k*DW +: DW] = 32'(32'hB0 + 16*k + j);
            tick();
        end
        in_vld = '0;
        chk("rr_first_vld", {63'd0, out_vld}, 64'd1);
        chk("rr_first_data", {32'd0, out_data}, 64'hB0);
        chk("rr_first_ch", {62'd0, out_ch}, 64'd0);
        out_rdy = 1'b1;
        for (int n = 1; n < 8; n++) begin
            tick();
            chk("rr_vld", {63'd0, out_vld}, 64'd1);
            chk("rr_ch", {62'd0, out_ch}, 64'(n % NC));
            chk("rr_data", {32'd0, out_data}, 64'(32'hB0 + 16*(n % NC) + n / NC));
        end
        tick();
        chk("rr_end_vld", {63'd0, out_vld}, 64'd0);

        // Backpressure: ch0 offers six words with out_rdy low; five fit (4 FIFO + 1 register)
        do_reset();
        w = 0;
        for (int c = 0; c < 8; c++) begin
            in_vld = 4'b0001;
            in_data[31:0] = 32'(32'hC0 + w);
            pre = in_rdy[0];
            tick();
            if (pre) w++;
        end
        chk("bp_accepted", 64'(w), 64'd5);
        chk("bp_rdy_low", {63'd0, in_rdy[0]}, 64'd0);
        chk("bp_out_vld", {63'd0, out_vld}, 64'd1);
        chk("bp_out_data", {32'd0, out_data}, 64'hC0);
        in_data[31:0] = 32'hC5;
        out_rdy = 1'b1;
        chk("full_pop_rdy_same", {63'd0, in_rdy[0]}, 64'd0);
        tick();
        chk("full_pop_rdy_next", {63'd0, in_rdy[0]}, 64'd1);
        chk("full_pop_data", {32'd0, out_data}, 64'hC1);
        tick();
        in_vld = '0;
        chk("push_pop_data", {32'd0, out_data}, 64'hC2);
        e = 3;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_vld) begin
                chk("bp_drain_data", {32'd0, out_data}, 64'(32'hC0 + e));
                e++;
            end
        end
        chk("bp_drain_count", 64'(e), 64'd6);
        chk("bp_drain_end", {63'd0, out_vld}, 64'd0);

        // Reset mid-stream with three words queued on ch1 and one held in the output register
        do_reset();
        for (int j = 0; j < 4; j++) begin
            in_vld = 4'b0010;
            in_data[63:32] = 32'(32'hD0 + j);
            tick();
        end
        in_vld = '0;
        chk("mid_pre_vld", {63'd0, out_vld}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_vld", {63'd0, out_vld}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_in_rdy", {60'd0, in_rdy}, 64'hF);
        out_rdy = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (out_vld) stale++;
        end
        chk("mid_no_stale", 64'(stale), 64'd0);

        // Randomized traffic, alternating loose, heavy and no backpressure
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mode = (cyc / 200) % 3;
            in_vld = 4'($urandom);
            in_data = {$urandom, $urandom, $urandom, $urandom};
            if (mode == 0)      out_rdy = ($urandom_range(0, 3) != 0);
            else if (mode == 1) out_rdy = ($urandom_range(0, 3) == 0);
            else                out_rdy = 1'b1;
            model_step();
        end

`ifdef BLOCKC_MERGE_STATS_EN
        // Saturation: one handshake per cycle from ch0 well past 16'hFFFF
        do_reset();
        out_rdy = 1'b1;
        for (int cyc = 0; cyc < 65600; cyc++) begin
            in_vld = 4'b0001;
            in_data[31:0] = $urandom;
            model_step();
        end
        chk("xfer_cnt_sat", {48'd0, out_xfer_cnt}, 64'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
